// File: rtl/sorted_frame_serializer.sv
// Captures a sorted 4-byte frame on done_in and streams it over valid/ready, tagging the last byte.
// Also flags out-of-order frames, sticky-flags frames dropped while busy, and counts completed frames.
module sorted_frame_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done_in,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic [WIDTH-1:0] data_in_2,
  input  logic [WIDTH-1:0] data_in_3,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             order_err,
  output logic             overrun,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] frame_buf [4];
  logic [1:0]       idx, idx_nxt, idx_inc;
  logic             capture, xfer;
  logic             out_valid_nxt, out_last_nxt, busy_nxt, order_err_nxt, overrun_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [7:0]       frame_cnt_nxt;

  assign xfer    = out_valid && out_ready;
  assign idx_inc = idx + 2'd1;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    capture       = 1'b0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    busy_nxt      = busy;
    order_err_nxt = order_err;
    overrun_nxt   = overrun;
    frame_cnt_nxt = frame_cnt;

    case (state)
      IDLE: begin
        if (done_in) capture = 1'b1;
      end
      SEND: begin
        if (xfer && idx != 2'd3) begin
          idx_nxt      = idx_inc;
          out_data_nxt = frame_buf[idx_inc];
          out_last_nxt = (idx_inc == 2'd3);
        end else if (xfer) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (done_in) begin
            capture = 1'b1;
          end else begin
            state_nxt     = IDLE;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            busy_nxt      = 1'b0;
          end
        end
        // Only the final-transfer cycle can absorb a new frame; anything earlier is lost.
        if (done_in && !(xfer && idx == 2'd3)) overrun_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (capture) begin
      state_nxt     = SEND;
      idx_nxt       = 2'd0;
      out_valid_nxt = 1'b1;
      out_data_nxt  = data_in_0;
      out_last_nxt  = 1'b0;
      busy_nxt      = 1'b1;
      order_err_nxt = (data_in_0 > data_in_1) | (data_in_1 > data_in_2) |
                      (data_in_2 > data_in_3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      order_err <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= 8'd0;
      for (int i = 0; i < 4; i++) frame_buf[i] <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      order_err <= order_err_nxt;
      overrun   <= overrun_nxt;
      frame_cnt <= frame_cnt_nxt;
      if (capture) begin
        frame_buf[0] <= data_in_0;
        frame_buf[1] <= data_in_1;
        frame_buf[2] <= data_in_2;
        frame_buf[3] <= data_in_3;
      end
    end
  end

endmodule

// File: tb/tb_sorted_frame_serializer.sv
// Bench for sorted_frame_serializer: a queue-based model of pending bytes checked every cycle,
// plus directed frames whose accepted byte streams are compared against hand-written literals.
module tb_sorted_frame_serializer;

  logic       clk = 1'b0;
  logic       reset, done_in, out_ready;
  logic [7:0] d0, d1, d2, d3;
  logic       out_valid, out_last, busy, order_err, overrun;
  logic [7:0] out_data, frame_cnt;

  int checks = 0;
  int failures = 0;

  sorted_frame_serializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .done_in(done_in),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .order_err(order_err), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Model: queue of bytes still owed downstream, encoded as last*256 + byte.
  int mq[$];
  int got[$];
  bit m_on = 1'b0;
  int m_data = 0;
  int m_cnt = 0;
  bit m_order = 1'b0;
  bit m_over = 1'b0;
  bit e_valid, e_last, m_xfer, m_accept;
  int e_data;

  always @(negedge clk) begin
    if (m_on) begin
      e_valid = (mq.size() > 0);
      e_data  = e_valid ? (mq[0] % 256) : m_data;
      e_last  = e_valid && (mq[0] >= 256);
      checks++;
      if (out_valid !== e_valid || out_data !== 8'(e_data) || out_last !== e_last ||
          busy !== e_valid || order_err !== m_order || overrun !== m_over ||
          frame_cnt !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t dut v=%0b d=%0d l=%0b b=%0b oe=%0b ov=%0b cnt=%0d want v=%0b d=%0d l=%0b b=%0b oe=%0b ov=%0b cnt=%0d",
                 $time, out_valid, out_data, out_last, busy, order_err, overrun, frame_cnt,
                 e_valid, e_data, e_last, e_valid, m_order, m_over, m_cnt);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(int'(out_last) * 256 + int'(out_data));
    end
    if (reset) begin
      mq.delete();
      m_data = 0; m_cnt = 0; m_order = 1'b0; m_over = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      m_xfer   = (mq.size() > 0) && out_ready;
      m_accept = done_in && (mq.size() == 0 || (m_xfer && mq.size() == 1));
      if (m_xfer) begin
        m_data = mq[0] % 256;
        if (mq[0] >= 256) m_cnt = (m_cnt + 1) % 256;
        void'(mq.pop_front());
      end
      if (m_accept) begin
        mq.push_back(int'(d0)); mq.push_back(int'(d1));
        mq.push_back(int'(d2)); mq.push_back(256 + int'(d3));
        m_order = (d0 > d1) || (d1 > d2) || (d2 > d3);
      end else if (done_in) begin
        m_over = 1'b1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    done_in = 1'b1; d0 = a; d1 = b; d2 = c; d3 = d;
    tick();
    done_in = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Expected entries use last*256 + byte.
  task automatic chk_stream(input string nm, input int n, input int e[8]);
    int bad;
    bad = -1;
    checks++;
    if (got.size() != n) bad = 99;
    else for (int i = 0; i < n; i++) if (got[i] != e[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      failures++;
      if (bad == 99) $display("FAIL %s stream length got=%0d want=%0d", nm, got.size(), n);
      else $display("FAIL %s byte %0d got=%0d want=%0d", nm, bad, got[bad], e[bad]);
    end
  endtask

  int exp8[8];

  initial begin
    reset = 1'b1; done_in = 1'b0; out_ready = 1'b0;
    d0 = 8'd0; d1 = 8'd0; d2 = 8'd0; d3 = 8'd0;
    tick(2);
    reset = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_order", int'(order_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", int'(out_valid), 0);
    end

    // Single frame
    got.delete();
    send_frame(8'd3, 8'd7, 8'd7, 8'd200);
    chk("single_first_valid", int'(out_valid), 1);
    chk("single_first_data", int'(out_data), 3);
    tick(4);
    exp8 = '{3, 7, 7, 456, 0, 0, 0, 0};
    chk_stream("single_stream", 4, exp8);
    chk("single_cnt", int'(frame_cnt), 1);
    chk("single_order", int'(order_err), 0);
    chk("single_busy", int'(busy), 0);
    chk("single_hold_data", int'(out_data), 200);

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
    begin
      int pat[7];
      pat = '{1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 7; i++) begin
        out_ready = pat[i][0];
        tick();
      end
    end
    out_ready = 1'b1;
    exp8 = '{1, 2, 3, 260, 0, 0, 0, 0};
    chk_stream("bp_stream", 4, exp8);
    chk("bp_cnt", int'(frame_cnt), 2);

    // Order error and overrun
    got.delete();
    send_frame(8'd9, 8'd5, 8'd6, 8'd7);
    chk("oe_order", int'(order_err), 1);
    tick();
    send_frame(8'd0, 8'd0, 8'd0, 8'd0);
    chk("oe_overrun", int'(overrun), 1);
    chk("oe_order_kept", int'(order_err), 1);
    tick(2);
    exp8 = '{9, 5, 6, 263, 0, 0, 0, 0};
    chk_stream("oe_stream", 4, exp8);
    chk("oe_busy", int'(busy), 0);
    send_frame(8'd1, 8'd1, 8'd2, 8'd2);
    tick(4);
    chk("oe_order_clear", int'(order_err), 0);
    chk("oe_overrun_sticky", int'(overrun), 1);
    chk("oe_cnt", int'(frame_cnt), 4);

    // Back-to-back
    got.delete();
    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
    tick(3);
    send_frame(8'd5, 8'd6, 8'd7, 8'd8);
    chk("b2b_busy_mid", int'(busy), 1);
    chk("b2b_data_mid", int'(out_data), 5);
    tick(4);
    exp8 = '{1, 2, 3, 260, 5, 6, 7, 264};
    chk_stream("b2b_stream", 8, exp8);
    chk("b2b_cnt", int'(frame_cnt), 6);

    // 250 more frames bring the count from 6 through 255 to 0
    for (int i = 0; i < 250; i++) begin
      send_frame(8'(i), 8'(i * 7), 8'(i * 7 + 1), 8'd255);
      tick(4);
    end
    chk("wrap_cnt", int'(frame_cnt), 0);

    // Reset mid-frame
    got.delete();
    send_frame(8'd10, 8'd20, 8'd30, 8'd40);
    tick(2);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp8 = '{10, 20, 0, 0, 0, 0, 0, 0};
    chk_stream("mid_rst_partial", 2, exp8);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_cnt", int'(frame_cnt), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    got.delete();
    out_ready = 1'b1;
    send_frame(8'd11, 8'd22, 8'd33, 8'd44);
    tick(4);
    exp8 = '{11, 22, 33, 300, 0, 0, 0, 0};
    chk_stream("mid_rst_next", 4, exp8);
    chk("mid_rst_next_cnt", int'(frame_cnt), 1);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
